// File: rtl/uart_rx_ctrl.sv
// 16x-oversampling UART receiver front end: synchronizer, baud prescaler and
// frame FSM that emits one majority-voted sample strobe per bit plus frame status.
module uart_rx_ctrl #(
    parameter logic VERIFY_ON   = 1'b0,
    parameter logic VERIFY_EVEN = 1'b0
) (
    input  logic        clk_i,
    input  logic        resetn_i,
    input  logic        uart_rx_i,
    input  logic [15:0] baud_div_i,
    output logic        sample_en_o,
    output logic        sample_bit_o,
    output logic [1:0]  phase_o,
    output logic [2:0]  bit_idx_o,
    output logic        busy_o,
    output logic        frame_done_o,
    output logic        frame_err_o,
    output logic        parity_err_o
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_e;

    localparam logic [1:0] PH_START  = 2'd0;
    localparam logic [1:0] PH_DATA   = 2'd1;
    localparam logic [1:0] PH_PARITY = 2'd2;
    localparam logic [1:0] PH_STOP   = 2'd3;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    // acc already holds the XOR of all data bits; adding the parity bit must
    // land on 0 for even parity and 1 for odd parity.
    function automatic logic parity_ok(input logic acc, input logic pbit);
        return (acc ^ pbit) == (VERIFY_EVEN ? 1'b0 : 1'b1);
    endfunction

    logic        rx_meta_q, rx_meta_d;
    logic        rx_sync_q, rx_sync_d;
    logic [15:0] cnt_q, cnt_d;
    state_e      state_q, state_d;
    logic [3:0]  os_cnt_q, os_cnt_d;
    logic [2:0]  bit_cnt_q, bit_cnt_d;
    logic        acc_q, acc_d;
    logic        par_mis_q, par_mis_d;
    logic [1:0]  cap_q, cap_d;
    logic        sample_en_q, sample_en_d;
    logic        sample_bit_q, sample_bit_d;
    logic [1:0]  phase_q, phase_d;
    logic [2:0]  bit_idx_q, bit_idx_d;
    logic        busy_q, busy_d;
    logic        frame_done_q, frame_done_d;
    logic        frame_err_q, frame_err_d;
    logic        parity_err_q, parity_err_d;

    logic        tick_s;
    logic        maj_s;

    // The >= compare lets a shrinking baud_div_i restart the count cleanly.
    assign tick_s = (cnt_q >= baud_div_i);
    // Third vote is the live synchronized line on the os_cnt=9 tick.
    assign maj_s  = maj3(cap_q[0], cap_q[1], rx_sync_q);

    // Next-state logic for synchronizer, prescaler, frame FSM and output strobes.
    always_comb begin
        rx_meta_d    = uart_rx_i;
        rx_sync_d    = rx_meta_q;
        cnt_d        = tick_s ? 16'd0 : (cnt_q + 16'd1);
        state_d      = state_q;
        os_cnt_d     = os_cnt_q;
        bit_cnt_d    = bit_cnt_q;
        acc_d        = acc_q;
        par_mis_d    = par_mis_q;
        cap_d        = cap_q;
        sample_en_d  = 1'b0;
        sample_bit_d = 1'b0;
        phase_d      = PH_START;
        bit_idx_d    = 3'd0;
        frame_done_d = 1'b0;
        frame_err_d  = 1'b0;
        parity_err_d = 1'b0;

        if (!tick_s) begin
            state_d = state_q;
        end else if (state_q == ST_IDLE) begin
            if (!rx_sync_q) begin
                state_d   = ST_START;
                os_cnt_d  = 4'd0;
                bit_cnt_d = 3'd0;
                acc_d     = 1'b0;
                par_mis_d = 1'b0;
            end else begin
                state_d = ST_IDLE;
            end
        end else begin
            os_cnt_d = os_cnt_q + 4'd1;
            if (os_cnt_q == 4'd7) begin
                cap_d[0] = rx_sync_q;
            end else if (os_cnt_q == 4'd8) begin
                cap_d[1] = rx_sync_q;
            end else begin
                cap_d = cap_q;
            end

            if (os_cnt_q == 4'd9) begin
                case (state_q)
                    ST_START: begin
                        if (maj_s) begin
                            state_d = ST_IDLE;
                        end else begin
                            sample_en_d  = 1'b1;
                            sample_bit_d = maj_s;
                            phase_d      = PH_START;
                        end
                    end
                    ST_DATA: begin
                        sample_en_d  = 1'b1;
                        sample_bit_d = maj_s;
                        phase_d      = PH_DATA;
                        bit_idx_d    = bit_cnt_q;
                        acc_d        = acc_q ^ maj_s;
                    end
                    ST_PARITY: begin
                        sample_en_d  = 1'b1;
                        sample_bit_d = maj_s;
                        phase_d      = PH_PARITY;
                        par_mis_d    = ~parity_ok(acc_q, maj_s);
                    end
                    ST_STOP: begin
                        // Leave at the bit centre so a following start edge is not missed.
                        sample_en_d  = 1'b1;
                        sample_bit_d = maj_s;
                        phase_d      = PH_STOP;
                        frame_done_d = 1'b1;
                        frame_err_d  = ~maj_s;
                        parity_err_d = par_mis_q;
                        state_d      = ST_IDLE;
                    end
                    default: begin
                        state_d = ST_IDLE;
                    end
                endcase
            end else if (os_cnt_q == 4'd15) begin
                case (state_q)
                    ST_START: begin
                        state_d = ST_DATA;
                    end
                    ST_DATA: begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            state_d = VERIFY_ON ? ST_PARITY : ST_STOP;
                        end else begin
                            state_d = ST_DATA;
                        end
                    end
                    ST_PARITY: begin
                        state_d = ST_STOP;
                    end
                    default: begin
                        state_d = state_q;
                    end
                endcase
            end else begin
                state_d = state_q;
            end
        end

        busy_d = (state_d != ST_IDLE);
    end

    // State and output registers; asynchronous reset returns everything to idle.
    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            rx_meta_q    <= 1'b1;
            rx_sync_q    <= 1'b1;
            cnt_q        <= 16'd0;
            state_q      <= ST_IDLE;
            os_cnt_q     <= 4'd0;
            bit_cnt_q    <= 3'd0;
            acc_q        <= 1'b0;
            par_mis_q    <= 1'b0;
            cap_q        <= 2'b00;
            sample_en_q  <= 1'b0;
            sample_bit_q <= 1'b0;
            phase_q      <= 2'd0;
            bit_idx_q    <= 3'd0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
            frame_err_q  <= 1'b0;
            parity_err_q <= 1'b0;
        end else begin
            rx_meta_q    <= rx_meta_d;
            rx_sync_q    <= rx_sync_d;
            cnt_q        <= cnt_d;
            state_q      <= state_d;
            os_cnt_q     <= os_cnt_d;
            bit_cnt_q    <= bit_cnt_d;
            acc_q        <= acc_d;
            par_mis_q    <= par_mis_d;
            cap_q        <= cap_d;
            sample_en_q  <= sample_en_d;
            sample_bit_q <= sample_bit_d;
            phase_q      <= phase_d;
            bit_idx_q    <= bit_idx_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
            frame_err_q  <= frame_err_d;
            parity_err_q <= parity_err_d;
        end
    end

    assign sample_en_o  = sample_en_q;
    assign sample_bit_o = sample_bit_q;
    assign phase_o      = phase_q;
    assign bit_idx_o    = bit_idx_q;
    assign busy_o       = busy_q;
    assign frame_done_o = frame_done_q;
    assign frame_err_o  = frame_err_q;
    assign parity_err_o = parity_err_q;

endmodule

// File: doc/uart_rx_ctrl.md
UART_RX_CTRL -- requirements
Module: uart_rx_ctrl

Interface
REQ-001 Parameter VERIFY_ON, default 1'b0: 1 = a parity bit follows the 8 data bits.
REQ-002 Parameter VERIFY_EVEN, default 1'b0: 1 = even parity, 0 = odd parity; ignored when VERIFY_ON=0.
REQ-003 clk_i  input  1  single block clock; all logic SHALL be on its rising edge.
REQ-004 resetn_i  input  1  reset, asynchronous assert, active-low.
REQ-005 uart_rx_i  input  1  asynchronous serial line, idle high.
REQ-006 baud_div_i  input  16  clk_i cycles per 1/16 bit period, minus 1.
REQ-007 sample_en_o  output  1  one-cycle strobe: one bit-centre sample is valid.
REQ-008 sample_bit_o  output  1  majority-voted bit value; valid when sample_en_o=1.
REQ-009 phase_o  output  2  phase of the current sample: 0=START, 1=DATA, 2=PARITY, 3=STOP.
REQ-010 bit_idx_o  output  3  data bit index 0..7; valid when phase_o=DATA.
REQ-011 busy_o  output  1  high while a frame is in progress.
REQ-012 frame_done_o  output  1  one-cycle pulse on the STOP sample.
REQ-013 frame_err_o  output  1  one-cycle pulse together with frame_done_o when the stop bit is 0.
REQ-014 parity_err_o  output  1  one-cycle pulse together with frame_done_o on a parity mismatch (VERIFY_ON=1 only).

Function
REQ-015 uart_rx_i SHALL pass through a 2-flop synchronizer; both flops SHALL reset to 1.
REQ-016 Prescaler: 16-bit counter, free-running; tick when cnt >= baud_div_i, then cnt <= 0, else cnt+1; baud_div_i=0 gives a tick every cycle; baud_div_i changes take effect without glitch at the next compare.
REQ-017 FSM states: IDLE, START, DATA, PARITY, STOP; 4-bit oversample counter os_cnt, 3-bit bit counter.
REQ-018 IDLE: on a tick with synced rx=0 -> START, os_cnt <= 0, bit counter <= 0, parity accumulator <= 0.
REQ-019 In non-IDLE states, each tick captures synced rx when pre-increment os_cnt is 7, 8 or 9, then increments os_cnt (wraps 15->0).
REQ-020 The majority of the three captures SHALL be evaluated on the os_cnt=9 tick; sample_en_o, sample_bit_o, phase_o and bit_idx_o SHALL be registered outputs, high/valid for exactly the following cycle.
REQ-021 START: majority=1 -> false start, return to IDLE, no sample_en_o; majority=0 -> strobe with phase 0, advance to DATA on the os_cnt=15 tick.
REQ-022 DATA: strobe per bit, bit_idx_o = bit counter; XOR the bit into the parity accumulator; on the os_cnt=15 tick, bit counter+1; after bit 7 -> PARITY if VERIFY_ON else STOP.
REQ-023 PARITY: strobe with phase 2; acc ^ bit must equal 0 (even) or 1 (odd), otherwise flag a mismatch; -> STOP on the os_cnt=15 tick.
REQ-024 STOP: on the os_cnt=9 evaluation, strobe with phase 3, pulse frame_done_o, pulse frame_err_o if majority=0, pulse parity_err_o if a mismatch was flagged; -> IDLE immediately (no wait for os_cnt=15) to allow back-to-back frames.
REQ-025 busy_o SHALL be registered: 1 in every state except IDLE.
REQ-026 A line still low in IDLE after a framing error SHALL start a new frame at the next tick (break is not filtered).

Reset
REQ-027 resetn_i low SHALL immediately (asynchronously) force IDLE, clear all counters and the parity flag, set the synchronizer to 1, and drive all outputs to 0, including mid-frame.
REQ-028 After resetn_i deasserts, the first frame SHALL be detected only on a new low level after at least one tick.

Verification
REQ-029 baud_div_i=0, VERIFY_ON=0, send 0x55 (16 clk/bit) -> first sample_en_o high on the 13th rising edge after uart_rx_i falls; 10 strobes, sample bits 0,1,0,1,0,1,0,1,0,1; phases 0,1x8,3; frame_done_o=1; frame_err_o=0.
REQ-030 Low glitch of 4 clk on an idle line with baud_div_i=0 -> busy_o rises then falls; no sample_en_o; no frame_done_o.
REQ-031 VERIFY_ON=1, VERIFY_EVEN=1, send 0x03 with parity bit 1 -> parity_err_o=1 with frame_done_o; with parity bit 0 -> parity_err_o=0.
REQ-032 Send 0xA5 with stop bit forced to 0 -> frame_err_o=1 and frame_done_o=1 in the same cycle; the next frame (0x3C) is received with 0 errors.
REQ-033 resetn_i pulsed low during DATA bit 4 -> all outputs 0 during reset and after it; the next complete frame (0x81) yields exactly 10 strobes with the correct bits.
REQ-034 baud_div_i=3, two back-to-back frames 0xFF then 0x00, no idle gap -> 20 strobes, 2 frame_done_o pulses, no errors.
